mux8_rr: RTL and testbench

- 8-to-1 registered round-robin multiplexer.
- Merges eight valid/ready input channels onto a single valid/ready output, tagging each word with its 3-bit source channel number.
- Counterpart to the 1-to-8 demux: `out_sel` uses the same encoding as the demux select lines (a = `out_sel[2]`, b = `out_sel[1]`, c = `out_sel[0]`), so `out_sel`/`out_data` can drive the demux directly to fan traffic back out.

---
 rtl/mux8_rr.sv | 101 ++++++++++
 tb/tb_mux8_rr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr.sv
// mux8_rr: 8-to-1 registered mux tagging each word with its 3-bit source channel.
// Round-robin arbitration when MUX8_RR_EN is defined, otherwise fixed priority (channel 0 highest).
module mux8_rr #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [7:0]     in_valid,
  input  logic [8*W-1:0] in_data,
  output logic [7:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_sel,
  input  logic           out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic [2:0]     sel_q, sel_d;
  logic           can_load;
  logic           gnt_any;
  logic [2:0]     gnt_idx;
  logic           xfer_in;

`ifdef MUX8_RR_EN
  logic [2:0] last_q, last_d;
  logic [2:0] cand;

  // Search upward from last+1; k=8 wraps back onto last itself.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 3'd0;
    cand    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (!gnt_any && in_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign last_d = xfer_in ? gnt_idx : last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 3'd7;
    else        last_q <= last_d;
  end
`else
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 3'd0;
    for (int c = 7; c >= 0; c--) begin
      if (in_valid[c]) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(c);
      end
    end
  end
`endif

  assign can_load = (state_q == EMPTY) || out_ready;
  assign xfer_in  = rst_n && en && can_load && gnt_any;
  assign in_ready = xfer_in ? (8'd1 << gnt_idx) : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer_in) begin
      state_d = FULL;
      data_d  = in_data[int'(gnt_idx)*W +: W];
      sel_d   = gnt_idx;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    out_valid = (state_q == FULL);
    out_data  = data_q;
    out_sel   = sel_q;
  end

endmodule

// File: tb/tb_mux8_rr.sv
// Self-checking bench for mux8_rr: directed vector table, round-robin sequence, randomized run vs. reference model.
module tb_mux8_rr;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux8_rr #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  // Reference model state
  logic         m_vld = 1'b0;
  logic [W-1:0] m_dat = '0;
  int           m_sel = 0;
  int           m_last = 7;
  logic [7:0]   last_rdy;
  logic [7:0]   cap_rdy;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_ready();
    if (!rst_n || !en || (m_vld && !out_ready) || in_valid == 8'h00) return 8'h00;
`ifdef MUX8_RR_EN
    for (int k = 1; k <= 8; k++) begin
      int c = (m_last + k) % 8;
      if (in_valid[c]) return 8'(1 << c);
    end
`else
    for (int c = 0; c < 8; c++)
      if (in_valid[c]) return 8'(1 << c);
`endif
    return 8'h00;
  endfunction

  // One clock: check in_ready before the edge, advance model, check outputs after it.
  task automatic step();
    logic [7:0] er;
    #1;
    er = ref_ready();
    last_rdy = er;
    cap_rdy = in_ready;
    check("in_ready", in_ready, er);
    @(posedge clk);
    if (!rst_n) begin
      m_vld = 1'b0; m_dat = '0; m_sel = 0; m_last = 7;
    end else if (er != 8'h00) begin
      for (int c = 0; c < 8; c++) begin
        if (er[c]) begin
          m_vld = 1'b1; m_dat = in_data[c*W +: W]; m_sel = c; m_last = c;
        end
      end
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    #1;
    check("out_valid", out_valid, m_vld);
    check("out_sel", out_sel, m_sel[2:0]);
    check("out_data", out_data, m_dat);
  endtask

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [7:0] vld;
    logic       ordy;
    logic [7:0] exp_rdy;
    logic       exp_ov;
    logic [2:0] exp_sel;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t tbl [18];
  logic [7:0] hold;
  logic [W-1:0] hdat [8];

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 8'hFF; out_ready = 1'b0; in_data = '0;
    hold = 8'h00;

    // Reset held for two cycles with all channels requesting
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_in_ready", cap_rdy, 8'h00);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_sel", out_sel, 3'd0);
    end

    //             rst  en   vld    ordy  rdy    ov    sel   dat
    tbl[0]  = '{1'b1, 1'b1, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 8'hA5};
    tbl[1]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 8'hA5};
    tbl[2]  = '{1'b1, 1'b1, 8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 8'hA3};
    tbl[3]  = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 3'd3, 8'hA3};
    tbl[4]  = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 3'd3, 8'hA3};
    tbl[5]  = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 3'd3, 8'hA3};
    tbl[6]  = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 3'd3, 8'hA3};
    tbl[7]  = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1, 3'd4, 8'hA4};
    tbl[8]  = '{1'b1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0, 3'd4, 8'hA4};
    tbl[9]  = '{1'b1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0, 3'd4, 8'hA4};
    tbl[10] = '{1'b1, 1'b1, 8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 8'hA0};
    tbl[11] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
    tbl[13] = '{1'b1, 1'b1, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0};
`ifdef MUX8_RR_EN
    tbl[14] = '{1'b1, 1'b1, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 8'hA7};
    tbl[15] = '{1'b1, 1'b1, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA2};
    tbl[16] = '{1'b1, 1'b1, 8'h0C, 1'b1, 8'h08, 1'b1, 3'd3, 8'hA3};
`else
    tbl[14] = '{1'b1, 1'b1, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0};
    tbl[15] = '{1'b1, 1'b1, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA2};
    tbl[16] = '{1'b1, 1'b1, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA2};
`endif
    tbl[17] = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 8'hA3};

    for (int c = 0; c < 8; c++) in_data[c*W +: W] = 8'hA0 + 8'(c);

    for (int i = 0; i < 18; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; in_valid = tbl[i].vld; out_ready = tbl[i].ordy;
      step();
      check($sformatf("row%0d_in_ready", i), cap_rdy, tbl[i].exp_rdy);
      check($sformatf("row%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      check($sformatf("row%0d_out_sel", i), out_sel, tbl[i].exp_sel);
      check($sformatf("row%0d_out_data", i), out_data, tbl[i].exp_dat);
    end

    // All eight requesting with out_ready high: grant order after reset
    rst_n = 1'b0; in_valid = 8'h00; out_ready = 1'b1; en = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 8'hFF;
    for (int c = 0; c < 8; c++) in_data[c*W +: W] = 8'(c);
    for (int k = 0; k < 9; k++) begin
      step();
`ifdef MUX8_RR_EN
      check($sformatf("rr_seq%0d_sel", k), out_sel, 3'(k % 8));
      check($sformatf("rr_seq%0d_data", k), out_data, 8'(k % 8));
`else
      check($sformatf("fp_seq%0d_sel", k), out_sel, 3'd0);
      check($sformatf("fp_seq%0d_data", k), out_data, 8'd0);
`endif
      check($sformatf("seq%0d_valid", k), out_valid, 1'b1);
    end

    // Randomized traffic; a channel's request and data stay put until transferred
    hold = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(63) != 0);
      en = ($urandom_range(7) != 0);
      out_ready = 1'($urandom_range(1));
      for (int c = 0; c < 8; c++) begin
        if (!hold[c] && $urandom_range(1) == 1) begin
          hold[c] = 1'b1;
          hdat[c] = W'($urandom);
        end
        in_data[c*W +: W] = hdat[c];
      end
      in_valid = hold;
      step();
      hold = hold & ~last_rdy;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
